vga_pin_decoder: RTL and testbench
==================================

// Module: vga_pin_decoder
// PURPOSE
// - Receive end of the VGA pin bus that the top level drives on uo_out: {hsync,B0,G0,R0,vsync,B1,G1,R1}.
// - Recovers pixel coordinates from the sync edges and emits a validated pixel stream (x, y, RGB222).
// - Used in loopback self-check and in the bench scoreboard to compare rendered frames against the entity inputs.
// - Pins are synchronous to clk; no CDC is performed.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_SYNC_START 656 : h coordinate of the first hsync-low sample (H_ACTIVE+front porch)
// - H_TOTAL 800 : clocks per line
// - V_ACTIVE 480 : visible lines per frame
// - V_SYNC_START 490 : v coordinate of the first vsync-low line
// - V_TOTAL 525 : lines per frame
// - RGB_DELAY 1 : clocks by which RGB pins lag the sync pins at the source, range 0..3
// PORTS
// - clk          in   1   pixel clock
// - rst_n        in   1   synchronous reset, active low
// - vga_pins     in   8   {hsync,B0,G0,R0,vsync,B1,G1,R1}; syncs are active low
// - pix_valid    out  1   pix_* describe one visible pixel this cycle
// - pix_x        out  10  column, 0..H_ACTIVE-1
// - pix_y        out  10  row, 0..V_ACTIVE-1
// - pix_rgb      out  6   {R1,R0,G1,G0,B1,B0}
// - frame_start  out  1   1-cycle pulse coincident with pixel (0,0)
// - locked       out  1   decoder is in the LOCKED state
// - sync_err     out  1   1-cycle pulse on a timing violation
// - frame_count  out  8   completed locked frames; wraps 255->0
// BEHAVIOUR
// - Reset: clock and reset as decided above (single clk; rst_n synchronous, active low).
//   - While rst_n=0, all outputs are 0, the FSM is in SEARCH, and the h/v counters and the sample history are cleared.
//   - Asserting reset mid-frame takes effect at the next edge and discards any partial frame.
// - Input path:
//   - vga_pins is registered once.
//   - Sync edges are detected between consecutive registered samples.
//   - RGB is delayed so that it aligns with the sync pipe as if RGB_DELAY were 0: sync pipe gets +RGB_DELAY stages.
// - Position tracking (h, v describe the current aligned sample):
//   - h increments each clock; at H_TOTAL-1 it wraps to 0 and v increments.
//   - v wraps at V_TOTAL-1 to 0.
//   - The first sample with hsync=0 after a sample with hsync=1 is assigned h=H_SYNC_START.
//   - The first sample with vsync=0 after a sample with vsync=1 is assigned v=V_SYNC_START; h is unaffected.
// - FSM states:
//   - SEARCH: counters free-running and ignored. On an hsync edge, load h and go to HLOCK.
//   - HLOCK: h is tracked.
//     - A vsync edge loads v and goes to LOCKED.
//     - An hsync edge at predicted h != H_SYNC_START reloads h, stays in HLOCK, and raises no error.
//   - LOCKED: sync edges are checked against the prediction.
//     - hsync edge with predicted h != H_SYNC_START: sync_err=1, reload h, go to HLOCK.
//     - vsync edge with predicted v != V_SYNC_START: sync_err=1, go to HLOCK.
//     - Predicted h == H_SYNC_START but hsync still 1 (missing sync): sync_err=1, go to SEARCH.
//     - If both errors hit in the same cycle: one sync_err pulse; SEARCH wins over HLOCK.
// - Outputs:
//   - pix_valid = LOCKED && h < H_ACTIVE && v < V_ACTIVE.
//   - pix_x, pix_y, pix_rgb are 0 when pix_valid=0.
//   - frame_start = pix_valid && h==0 && v==0.
//   - frame_count increments on the cycle where v wraps to 0 while LOCKED.
// - Latency: a pixel on the RGB pins at cycle t appears on pix_* at cycle t+2, independent of RGB_DELAY.
// - Output timing: all outputs are registered; sync_err and frame_start are never high longer than 1 cycle.
// TESTING
// - Reset: hold rst_n=0 for 5 clocks with random pins -> all outputs 0; after release, locked=0 until the first hsync and vsync edges.
// - Ideal 640x480 stream, RGB_DELAY=1, rgb=x[5:0] -> locked=1 at the first vsync edge.
//   - Next frame: exactly 307200 pix_valid cycles, each pix_rgb==pix_x[5:0].
//   - frame_start once, at pix_x=0, pix_y=0.
// - Line 100 hsync asserted 3 clocks early -> exactly 1 sync_err pulse, locked=0, no pix_valid until the next vsync edge; relocks with correct coordinates.
// - hsync held high for 2 lines while LOCKED -> sync_err at predicted h=656, FSM in SEARCH; relocks after hsync plus vsync edges.
// - 3 full frames locked -> frame_count=3; run 256 frames -> frame_count wraps to 0.
// - rst_n pulsed low at (x=320, y=240) -> outputs 0 the next cycle; no pix_valid until relock; frame_count=0.

Source files
------------

// File: rtl/vga_pin_decoder.sv
// Receive side of the VGA pin bus: recovers x/y from the sync edges and emits a
// validated RGB222 pixel stream, with lock tracking, sync error pulses and a frame counter.
module vga_pin_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int RGB_DELAY    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_pins,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [5:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [7:0] frame_count
);

    // state     | meaning
    // SEARCH    | no timing reference, counters ignored
    // HLOCK     | line timing tracked, waiting for a vsync edge
    // LOCKED    | frame timing tracked, pixels emitted, syncs checked
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_HLOCK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HSS = 10'(H_SYNC_START);
    localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VSS = 10'(V_SYNC_START);
    localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);

    logic [7:0]                pins_q, pins_d;
    logic [RGB_DELAY:0][1:0]   sh_q, sh_d;
    logic [RGB_DELAY+1:0][1:0] tap;
    logic [9:0]                h_q, h_d, v_q, v_d;
    logic [1:0]                state_q, state_d;
    logic                      pix_valid_q, pix_valid_d;
    logic [9:0]                pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [5:0]                pix_rgb_q, pix_rgb_d;
    logic                      frame_start_q, frame_start_d;
    logic                      locked_q, locked_d;
    logic                      sync_err_q, sync_err_d;
    logic [7:0]                frame_count_q, frame_count_d;

    logic       hs_cur, hs_prev, vs_cur, vs_prev, hs_edge, vs_edge;
    logic [9:0] h_now, v_now;
    logic       h_wrap;

    always_comb begin
        pins_d = vga_pins;
        // Sync taps are pushed back RGB_DELAY stages so they line up with the RGB in pins_q.
        tap    = '0;
        sh_d   = '0;
        tap[0] = {pins_q[7], pins_q[3]};
        for (int i = 0; i <= RGB_DELAY; i++) begin
            tap[i+1] = sh_q[i];
            sh_d[i]  = tap[i];
        end
        hs_cur  = tap[RGB_DELAY][1];
        vs_cur  = tap[RGB_DELAY][0];
        hs_prev = tap[RGB_DELAY+1][1];
        vs_prev = tap[RGB_DELAY+1][0];
        hs_edge = hs_prev & ~hs_cur;
        vs_edge = vs_prev & ~vs_cur;

        h_now  = hs_edge ? HSS : h_q;
        v_now  = vs_edge ? VSS : v_q;
        h_wrap = (h_now == HT1);
        h_d    = h_wrap ? 10'd0 : h_now + 10'd1;
        if (h_wrap) v_d = (v_now == VT1) ? 10'd0 : v_now + 10'd1;
        else        v_d = v_now;

        state_d    = state_q;
        sync_err_d = 1'b0;
        case (state_q)
            ST_SEARCH: if (hs_edge) state_d = ST_HLOCK;
            ST_HLOCK:  if (vs_edge) state_d = ST_LOCKED;
            ST_LOCKED: begin
                // A missing hsync loses the line reference entirely, so it outranks the HLOCK fallback.
                if (h_q == HSS && hs_cur) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_SEARCH;
                end else if ((hs_edge && h_q != HSS) || (vs_edge && v_q != VSS)) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_HLOCK;
                end
            end
            default:   state_d = ST_SEARCH;
        endcase

        locked_d      = (state_d == ST_LOCKED);
        pix_valid_d   = locked_d && (h_now < HA) && (v_now < VA);
        pix_x_d       = pix_valid_d ? h_now : 10'd0;
        pix_y_d       = pix_valid_d ? v_now : 10'd0;
        pix_rgb_d     = pix_valid_d ? {pins_q[0], pins_q[4], pins_q[1], pins_q[5], pins_q[2], pins_q[6]}
                                    : 6'd0;
        frame_start_d = pix_valid_d && (h_now == 10'd0) && (v_now == 10'd0);
        frame_count_d = (locked_d && h_wrap && v_now == VT1) ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pins_q        <= '0;
            sh_q          <= '0;
            h_q           <= '0;
            v_q           <= '0;
            state_q       <= ST_SEARCH;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            pins_q        <= pins_d;
            sh_q          <= sh_d;
            h_q           <= h_d;
            v_q           <= v_d;
            state_q       <= state_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pin_decoder.sv
// Directed bench for vga_pin_decoder on a shrunken 8x4 raster (14x7 totals) so
// that many frames, including a full frame_count wrap, fit in a short run.
module tb_vga_pin_decoder;

    localparam int HA    = 8;
    localparam int HSS   = 10;
    localparam int HT    = 14;
    localparam int VA    = 4;
    localparam int VSS   = 5;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_pins = 8'hFF;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [5:0] pix_rgb;
    logic       frame_start, locked, sync_err;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    int gx = 0, gy = 0;
    logic [5:0] prev_rgb = '0;
    int early_y = -1;
    int skip_a = -1, skip_b = -1;
    int ex1 = 0, ey1 = 0, ex2 = 0, ey2 = 0;
    int n_valid = 0, n_fs = 0, n_err = 0, n_bad = 0;
    logic last_fs = 1'b0, last_err = 1'b0;

    vga_pin_decoder #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_TOTAL(VT), .RGB_DELAY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_pins(vga_pins),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] enc(input int x, input int y);
        return 6'(x + 8 * y);
    endfunction

    // One pixel clock of the source: syncs for (gx,gy), RGB lagging one clock.
    task automatic step();
        logic hs, vs;
        if (gy == early_y)                  hs = !(gx >= HSS - 3 && gx < HSS - 1);
        else if (gy == skip_a || gy == skip_b) hs = 1'b1;
        else                                hs = !(gx >= HSS && gx < HSS + 2);
        vs = !(gy == VSS);
        vga_pins = {hs, prev_rgb[0], prev_rgb[2], prev_rgb[4], vs, prev_rgb[1], prev_rgb[3], prev_rgb[5]};
        prev_rgb = (gx < HA && gy < VA) ? enc(gx, gy) : 6'd0;
        @(posedge clk);
        #1;
        if (pix_valid) begin
            n_valid++;
            if (pix_x !== 10'(ex2) || pix_y !== 10'(ey2) || pix_rgb !== enc(ex2, ey2)) n_bad++;
        end else if (pix_x !== 10'd0 || pix_y !== 10'd0 || pix_rgb !== 6'd0) begin
            n_bad++;
        end
        if (frame_start) begin
            n_fs++;
            if (!pix_valid || pix_x !== 10'd0 || pix_y !== 10'd0 || last_fs) n_bad++;
        end
        if (sync_err) begin
            n_err++;
            if (last_err) n_bad++;
        end
        last_fs  = frame_start;
        last_err = sync_err;
        ex2 = ex1; ey2 = ey1;
        ex1 = gx;  ey1 = gy;
        if (gx == HT - 1) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        n_valid = 0; n_fs = 0; n_err = 0; n_bad = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vga_pins = 8'($urandom);
            @(posedge clk);
        end
        #1;
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, sync_err, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b x=%0d y=%0d rgb=%0h fs=%0b lk=%0b err=%0b fc=%0d, expected all 0",
                     pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, sync_err, frame_count);
        end
        gx = 0; gy = 0; prev_rgb = '0;
        rst_n = 1'b1;
        clear_counts();
        steps(VSS * HT);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL prelock_locked: got %0b expected 0", locked);
        end
        steps(FRAME - VSS * HT);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_vsync: got %0b expected 1", locked);
        end
        checks++;
        if (n_valid !== 0 || n_err !== 0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL first_frame: valid=%0d err=%0d fc=%0d expected 0 0 0", n_valid, n_err, frame_count);
        end
    endtask

    task automatic test_ideal_frame(input string tag, input int exp_fc);
        clear_counts();
        steps(FRAME);
        checks++;
        if (n_valid !== HA * VA) begin
            errors++;
            $display("FAIL %s_valid_count: got %0d expected %0d", tag, n_valid, HA * VA);
        end
        checks++;
        if (n_fs !== 1 || n_err !== 0 || n_bad !== 0) begin
            errors++;
            $display("FAIL %s_stream: fs=%0d err=%0d bad=%0d expected 1 0 0", tag, n_fs, n_err, n_bad);
        end
        checks++;
        if (frame_count !== 8'(exp_fc) || locked !== 1'b1) begin
            errors++;
            $display("FAIL %s_count: fc=%0d lk=%0b expected %0d 1", tag, frame_count, locked, exp_fc);
        end
    endtask

    task automatic test_frame_count();
        steps(2 * FRAME);
        checks++;
        if (frame_count !== 8'd3) begin
            errors++;
            $display("FAIL frame_count_3: got %0d expected 3", frame_count);
        end
    endtask

    task automatic test_early_hsync();
        clear_counts();
        early_y = 2;
        steps(3 * HT);
        checks++;
        if (n_err !== 1 || locked !== 1'b0 || n_valid !== 2 * HA + (HSS - 3)) begin
            errors++;
            $display("FAIL early_hsync: err=%0d lk=%0b valid=%0d expected 1 0 %0d", n_err, locked, n_valid, 2 * HA + HSS - 3);
        end
        steps(FRAME - 3 * HT);
        early_y = -1;
        checks++;
        if (n_err !== 1 || n_valid !== 2 * HA + (HSS - 3) || n_bad !== 0 || locked !== 1'b1 || frame_count !== 8'd4) begin
            errors++;
            $display("FAIL early_relock: err=%0d valid=%0d bad=%0d lk=%0b fc=%0d expected 1 %0d 0 1 4",
                     n_err, n_valid, n_bad, locked, frame_count, 2 * HA + HSS - 3);
        end
    endtask

    task automatic test_missing_hsync();
        clear_counts();
        skip_a = 1; skip_b = 2;
        steps(3 * HT);
        checks++;
        if (n_err !== 1 || locked !== 1'b0 || n_valid !== 2 * HA) begin
            errors++;
            $display("FAIL missing_hsync: err=%0d lk=%0b valid=%0d expected 1 0 %0d", n_err, locked, n_valid, 2 * HA);
        end
        skip_a = -1; skip_b = -1;
        steps(FRAME - 3 * HT);
        checks++;
        if (n_err !== 1 || n_valid !== 2 * HA || n_bad !== 0 || locked !== 1'b1 || frame_count !== 8'd6) begin
            errors++;
            $display("FAIL missing_relock: err=%0d valid=%0d bad=%0d lk=%0b fc=%0d expected 1 %0d 0 1 6",
                     n_err, n_valid, n_bad, locked, frame_count, 2 * HA);
        end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        steps(2 * HT + 4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, sync_err, frame_count} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got valid=%0b x=%0d y=%0d rgb=%0h lk=%0b fc=%0d expected all 0",
                     pix_valid, pix_x, pix_y, pix_rgb, locked, frame_count);
        end
        clear_counts();
        steps(FRAME - 2 * HT - 5);
        checks++;
        if (n_valid !== 0 || locked !== 1'b1 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL midframe_relock: valid=%0d lk=%0b fc=%0d expected 0 1 0", n_valid, locked, frame_count);
        end
    endtask

    task automatic test_count_wrap();
        steps(254 * FRAME);
        checks++;
        if (frame_count !== 8'd255) begin
            errors++;
            $display("FAIL count_255: got %0d expected 255", frame_count);
        end
        steps(FRAME);
        checks++;
        if (frame_count !== 8'd0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL count_wrap: fc=%0d lk=%0b expected 0 1", frame_count, locked);
        end
    endtask

    initial begin
        test_reset();
        test_ideal_frame("frame1", 1);
        test_frame_count();
        test_early_hsync();
        test_ideal_frame("after_early", 5);
        test_missing_hsync();
        test_ideal_frame("after_missing", 7);
        test_reset_midframe();
        test_ideal_frame("after_reset", 1);
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
